// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide sequencer that owns every HI/LO write.
// Signed operands are reduced to magnitudes on accept; the sign fixup is applied as the result registers load.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] res_q, res_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] araw_q, araw_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_step, div_step, step, prod_fix;
    logic [32:0] div_rem;
    logic [33:0] div_diff;
    logic [31:0] quo, rem;

    assign sgn_op = !req_op[2] && !req_op[0];
    assign a_neg  = sgn_op && req_a[31];
    assign b_neg  = sgn_op && req_b[31];
    assign a_mag  = a_neg ? (~req_a + 32'd1) : req_a;
    assign b_mag  = b_neg ? (~req_b + 32'd1) : req_b;

    // Multiply: res_q = {partial product, remaining multiplier bits}, shifting right each step.
    assign mul_sum  = {1'b0, res_q[63:32]} + {1'b0, (res_q[0] ? opnd_q : 32'd0)};
    assign mul_step = {mul_sum, res_q[31:1]};

    // Divide: res_q = {partial remainder, dividend bits turning into quotient bits}.
    assign div_rem  = {res_q[63:32], res_q[31]};
    assign div_diff = {1'b0, div_rem} - {2'b00, opnd_q};
    assign div_step = (div_diff[33:32] == 2'b00) ? {div_diff[31:0], res_q[30:0], 1'b1}
                                                 : {div_rem[31:0],  res_q[30:0], 1'b0};

    assign step     = op_q[1] ? div_step : mul_step;
    assign prod_fix = negq_q ? (~step + 64'd1) : step;
    assign quo      = step[31:0];
    assign rem      = step[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        opnd_d  = opnd_q;
        araw_d  = araw_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d  = req_op;
                    cnt_d = 5'd0;
                    if (!req_op[2]) begin
                        state_d = S_RUN;
                        araw_d  = req_a;
                        dz_d    = (req_b == 32'd0);
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        if (req_op[1]) begin
                            res_d  = {32'd0, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            res_d  = {32'd0, b_mag};
                            opnd_d = a_mag;
                        end
                    end else begin
                        state_d = S_FIN;
                        if (req_op == 3'd4) hi_d = req_a;
                        if (req_op == 3'd5) lo_d = req_a;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                res_d = step;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIN;
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (dz_q) begin
                        hi_d = araw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = negr_q ? (~rem + 32'd1) : rem;
                        lo_d = negq_q ? (~quo + 32'd1) : quo;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An aborted operation must not disturb the visible HI/LO values.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            res_q   <= 64'd0;
            opnd_q  <= 32'd0;
            araw_q  <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            opnd_q  <= opnd_d;
            araw_q  <= araw_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !flush;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN) && !flush;
    assign hi_write  = done && (!op_q[2] || op_q == 3'd4);
    assign lo_write  = done && (!op_q[2] || op_q == 3'd5);
    assign hi_data   = hi_q;
    assign lo_data   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random ops against a plain-arithmetic HI/LO model,
// plus flush, reset, reserved-op and back-to-back scenarios.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        req_ready, busy, done, hi_write, lo_write;
    logic [31:0] hi_data, lo_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    muldiv_ctrl dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
        .busy(busy), .done(done), .hi_write(hi_write), .lo_write(lo_write),
        .hi_data(hi_data), .lo_data(lo_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Architectural result of one op, from plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l,
                                  output logic wh, output logic wl);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'd0; l = 32'd0; wh = 1'b0; wl = 1'b0;
        case (op)
            3'd0: begin p = sa * sb; {h, l} = p; wh = 1; wl = 1; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; {h, l} = u; wh = 1; wl = 1; end
            3'd2: begin
                wh = 1; wl = 1;
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin p = sa % sb; h = p[31:0]; p = sa / sb; l = p[31:0]; end
            end
            3'd3: begin
                wh = 1; wl = 1;
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = a % b; l = a / b; end
            end
            3'd4: begin h = a; wh = 1; end
            3'd5: begin l = a; wl = 1; end
            default: ;
        endcase
    endfunction

    // Issue one request and observe it until the block returns to idle (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int fin_cyc, output int nbusy, output int ndone, output int done_at,
                          output logic hw, output logic lw, output logic [31:0] hd, output logic [31:0] ld);
        fin_cyc = 0; nbusy = 0; ndone = 0; done_at = 0; hw = 0; lw = 0; hd = 0; ld = 0;
        @(negedge clk);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++; fin_cyc = k; done_at = cyc;
                hw = hi_write; lw = lo_write; hd = hi_data; ld = lo_data;
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi_write, lo_write, hi_data, lo_data} !== 68'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b hw=%b lw=%b hi=%h lo=%h rdy=%b, required all 0, rdy=1",
                     busy, done, hi_write, lo_write, hi_data, lo_data, req_ready);
        end
        @(negedge clk); resetn = 1;
    endtask

    task automatic test_arith(input int nrand);
        logic [2:0]  t_op [9];
        logic [31:0] t_a [9], t_b [9], t_h [9], t_l [9];
        logic [2:0]  op;
        logic [31:0] a, b, eh, el, hd, ld;
        logic        ewh, ewl, hw, lw;
        int          fin, nb, nd, dat, lat;
        t_op = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
        t_a  = '{32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9,
                 32'd7, 32'h80000000, 32'd5, 32'hFFFFFFF9};
        t_b  = '{32'd3, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        t_h  = '{32'hFFFFFFFF, 32'h40000000, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                 32'd1, 32'd0, 32'd5, 32'hFFFFFFF9};
        t_l  = '{32'hFFFFFFFA, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFD,
                 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 9 + nrand; i++) begin
            if (i < 9) begin
                op = t_op[i]; a = t_a[i]; b = t_b[i];
                eh = t_h[i]; el = t_l[i]; ewh = 1; ewl = 1;
            end else begin
                op = 3'($urandom_range(0, 7));
                a  = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = $urandom_range(1, 20);
                    2: b = -$urandom_range(1, 20);
                    default: b = $urandom;
                endcase
                model(op, a, b, eh, el, ewh, ewl);
            end
            lat = (op < 3'd4) ? 33 : 1;
            run_op(op, a, b, fin, nb, nd, dat, hw, lw, hd, ld);
            checks++;
            if (fin != lat || nb != lat || nd != 1) begin
                errors++;
                $display("FAIL op%0d_timing a=%h b=%h fin=%0d busy=%0d done=%0d, required fin=%0d busy=%0d done=1",
                         op, a, b, fin, nb, nd, lat, lat);
            end
            checks++;
            if (hw !== ewh || lw !== ewl) begin
                errors++;
                $display("FAIL op%0d_wen a=%h b=%h hw=%b lw=%b, required %b %b", op, a, b, hw, lw, ewh, ewl);
            end
            checks++;
            if ((ewh && hd !== eh) || (ewl && ld !== el)) begin
                errors++;
                $display("FAIL op%0d_data a=%h b=%h hi=%h lo=%h, required hi=%h lo=%h", op, a, b, hd, ld, eh, el);
            end
            if (ewh) last_hi = eh;
            if (ewl) last_lo = el;
            checks++;
            if (hi_data !== last_hi || lo_data !== last_lo || hi_write || lo_write) begin
                errors++;
                $display("FAIL op%0d_hold hi=%h lo=%h, required hi=%h lo=%h", op, hi_data, lo_data, last_hi, last_lo);
            end
        end
    endtask

    task automatic test_back_to_back;
        int f1, b1, d1, at1, f2, b2, d2, at2;
        logic hw1, lw1, hw2, lw2;
        logic [31:0] hd1, ld1, hd2, ld2;
        run_op(3'd4, 32'h12345678, 32'd0, f1, b1, d1, at1, hw1, lw1, hd1, ld1);
        run_op(3'd5, 32'h9ABCDEF0, 32'd0, f2, b2, d2, at2, hw2, lw2, hd2, ld2);
        checks++;
        if (f1 != 1 || b1 != 1 || d1 != 1 || d2 != 1 || at2 - at1 != 2) begin
            errors++;
            $display("FAIL b2b_timing fin1=%0d busy1=%0d done1=%0d done2=%0d gap=%0d, required 1 1 1 1 2",
                     f1, b1, d1, d2, at2 - at1);
        end
        checks++;
        if ({hw1, lw1, hw2, lw2} !== 4'b1001 || hd1 !== 32'h12345678 || ld2 !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL b2b_writes wen=%b hi=%h lo=%h, required wen=1001 hi=12345678 lo=9abcdef0",
                     {hw1, lw1, hw2, lw2}, hd1, ld2);
        end
        last_hi = 32'h12345678; last_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_reserved;
        int f, nb, nd, at;
        logic hw, lw;
        logic [31:0] hd, ld;
        run_op(3'd6, $urandom, $urandom, f, nb, nd, at, hw, lw, hd, ld);
        checks++;
        if (f != 1 || nd != 1 || hw !== 1'b0 || lw !== 1'b0 || hi_data !== last_hi || lo_data !== last_lo) begin
            errors++;
            $display("FAIL reserved_op fin=%0d done=%0d hw=%b lw=%b hi=%h lo=%h, required 1 1 0 0 %h %h",
                     f, nd, hw, lw, hi_data, lo_data, last_hi, last_lo);
        end
    endtask

    task automatic test_flush_run;
        int bad;
        @(negedge clk);
        req_valid = 1; req_op = 3'd1; req_a = $urandom; req_b = $urandom;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1; #1;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_run_ready rdy=%b busy=%b, required 0 1", req_ready, busy);
        end
        @(posedge clk); #1; flush = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_run_idle busy=%b done=%b, required 0 0", busy, done);
        end
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || hi_write || lo_write || hi_data !== last_hi || lo_data !== last_lo) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_run_nowrite bad_cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_flush_block;
        int bad = 0;
        @(negedge clk);
        flush = 1; req_valid = 1; req_op = 3'd4; req_a = 32'hDEADBEEF;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || req_ready || done || hi_write) bad++;
        end
        @(negedge clk); flush = 0; req_valid = 0;
        @(posedge clk); #1;
        if (busy || hi_data !== last_hi) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_block bad_cycles=%0d, required 0", bad);
        end
    endtask

    task automatic test_flush_fin;
        logic [31:0] a, b, eh, el;
        logic ewh, ewl;
        a = $urandom; b = $urandom;
        model(3'd0, a, b, eh, el, ewh, ewl);
        @(negedge clk);
        req_valid = 1; req_op = 3'd0; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL flush_fin_pre done=%b, required 1", done);
        end
        flush = 1; #1;
        checks++;
        if ({done, hi_write, lo_write} !== 3'b000) begin
            errors++;
            $display("FAIL flush_fin_suppress done/hw/lw=%b, required 000", {done, hi_write, lo_write});
        end
        @(posedge clk); #1; flush = 0;
        // Result registers already took the fixed-up value on entry to FIN; only the write was suppressed.
        last_hi = eh; last_lo = el;
        checks++;
        if (busy !== 1'b0 || hi_data !== last_hi || lo_data !== last_lo) begin
            errors++;
            $display("FAIL flush_fin_after busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi_data, lo_data, eh, el);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        req_valid = 1; req_op = 3'd2; req_a = $urandom; req_b = $urandom;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk); resetn = 0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, hi_write, lo_write, hi_data, lo_data} !== 68'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midrun busy=%b done=%b hw=%b lw=%b hi=%h lo=%h rdy=%b, required all 0, rdy=1",
                     busy, done, hi_write, lo_write, hi_data, lo_data, req_ready);
        end
        @(negedge clk); resetn = 1;
        last_hi = 32'd0; last_lo = 32'd0;
        repeat (36) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || hi_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_release busy=%b rdy=%b hi=%h, required 0 1 0", busy, req_ready, hi_data);
        end
    endtask

    initial begin
        test_reset;
        test_arith(40);
        test_back_to_back;
        test_reserved;
        test_flush_run;
        test_flush_block;
        test_flush_fin;
        test_reset_midrun;
        test_arith(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
